// File: rtl/currctrl_bridge_pkg.sv
// Shared constants, FSM state type and byte-lane helpers for the current-control bus bridge
// responder.
package currctrl_bridge_pkg;

  // Register byte addresses
  localparam logic [6:0] ADDR_ID         = 7'h00;
  localparam logic [6:0] ADDR_CTRL       = 7'h04;
  localparam logic [6:0] ADDR_IRQ_STATUS = 7'h08;
  localparam logic [6:0] ADDR_IRQ_MASK   = 7'h0C;
  localparam logic [6:0] ADDR_STATUS     = 7'h10;
  localparam logic [6:0] ADDR_EVT_COUNT  = 7'h14;
  localparam logic [6:0] ADDR_RSVD0      = 7'h18;
  localparam logic [6:0] ADDR_RSVD1      = 7'h1C;
  localparam logic [6:0] PARAM_BASE      = 7'h20;

  // Word indices (byte address / 4)
  localparam logic [4:0] WIDX_ID         = ADDR_ID[6:2];
  localparam logic [4:0] WIDX_CTRL       = ADDR_CTRL[6:2];
  localparam logic [4:0] WIDX_IRQ_STATUS = ADDR_IRQ_STATUS[6:2];
  localparam logic [4:0] WIDX_IRQ_MASK   = ADDR_IRQ_MASK[6:2];
  localparam logic [4:0] WIDX_STATUS     = ADDR_STATUS[6:2];
  localparam logic [4:0] WIDX_EVT_COUNT  = ADDR_EVT_COUNT[6:2];
  localparam logic [4:0] WIDX_PARAM_BASE = PARAM_BASE[6:2];

  localparam int unsigned N_PARAM     = 24;
  localparam logic [4:0]  N_PARAM_IDX = 5'd24;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StAck,
    StRelease
  } bridge_state_e;

  // Expand a 4-bit byte enable into a 32-bit bit mask.
  function automatic logic [31:0] be_mask(input logic [3:0] be);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) m[8*i +: 8] = 8'hFF;
    end
    return m;
  endfunction

  // Replace only the enabled byte lanes of old_val with new_val.
  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] m;
    m = be_mask(be);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/currctrl_param_file.sv
// 24 x 32 parameter storage: byte-enabled write port, combinational bus read port and a
// registered read port for the coil-driver logic.
module currctrl_param_file
  import currctrl_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  wr_idx,
  input  logic [3:0]  wr_be,
  input  logic [31:0] wr_data,
  input  logic [4:0]  bus_idx,
  output logic [31:0] bus_rdata,
  input  logic [4:0]  rd_idx,
  output logic [31:0] rd_data
);

  logic [31:0] mem_q [N_PARAM];

  // Storage update; reset clears every entry, writes merge enabled byte lanes.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_PARAM; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en && (wr_idx < N_PARAM_IDX)) begin
      mem_q[wr_idx] <= be_merge(mem_q[wr_idx], wr_data, wr_be);
    end
  end

  // Internal read port; samples pre-write contents so a colliding write returns old data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data <= '0;
    end else if (rd_idx < N_PARAM_IDX) begin
      rd_data <= mem_q[rd_idx];
    end else begin
      rd_data <= '0;
    end
  end

  // Bus-side read, consumed by the responder FSM when it loads read_data.
  always_comb begin
    bus_rdata = '0;
    if (bus_idx < N_PARAM_IDX) bus_rdata = mem_q[bus_idx];
  end

endmodule

// File: rtl/currctrl_bridge_responder.sv
// Responder end of the current-control bus bridge: four-phase handshake FSM, control and
// interrupt registers, event counter and the parameter file.
module currctrl_bridge_responder
  import currctrl_bridge_pkg::*;
#(
  parameter logic [31:0] ID_VALUE = 32'h4344_0008,
  parameter int unsigned N_IRQ    = 8
) (
  input  logic             clk_clk,
  input  logic             reset_reset,
  input  logic             bus_enable,
  input  logic             rw,
  input  logic [6:0]       address,
  input  logic [3:0]       byte_enable,
  input  logic [31:0]      write_data,
  output logic             acknowledge,
  output logic [31:0]      read_data,
  output logic             irq,
  input  logic [N_IRQ-1:0] irq_src,
  input  logic [31:0]      status_in,
  output logic [31:0]      ctrl_out,
  input  logic [4:0]       param_rd_addr,
  output logic [31:0]      param_rd_data
);

  bridge_state_e state_q;
  logic          ack_q;
  logic [4:0]    widx_q;
  logic          rw_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;

  logic [31:0]      ctrl_q;
  logic [N_IRQ-1:0] irq_status_q, irq_status_d;
  logic [N_IRQ-1:0] irq_mask_q;
  logic [N_IRQ-1:0] irq_clr;
  logic [15:0]      evt_count_q;
  logic             irq_q;

  logic        commit_wr;
  logic        is_param;
  logic [4:0]  param_idx;
  logic [31:0] param_bus_rdata;
  logic [31:0] rd_mux;
  logic [31:0] clr_full;
  logic        wr_ctrl, wr_irq_status, wr_irq_mask, wr_evt_count;

  // Byte-offset bits carry no meaning on a word-wide register space.
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^address[1:0];

  // Writes commit on the edge that ends ACCESS.
  assign commit_wr = (state_q == StAccess) && !rw_q;
  assign is_param  = (widx_q >= WIDX_PARAM_BASE);
  assign param_idx = widx_q - WIDX_PARAM_BASE;

  // Register write decode for the latched word index.
  always_comb begin
    wr_ctrl       = 1'b0;
    wr_irq_status = 1'b0;
    wr_irq_mask   = 1'b0;
    wr_evt_count  = 1'b0;
    if (commit_wr && !is_param) begin
      case (widx_q)
        WIDX_CTRL:       wr_ctrl       = 1'b1;
        WIDX_IRQ_STATUS: wr_irq_status = 1'b1;
        WIDX_IRQ_MASK:   wr_irq_mask   = 1'b1;
        WIDX_EVT_COUNT:  wr_evt_count  = 1'b1;
        default: ;
      endcase
    end
  end

  // Read multiplexer over the whole register map; reserved words read as zero.
  always_comb begin
    rd_mux = '0;
    if (is_param) begin
      rd_mux = param_bus_rdata;
    end else begin
      case (widx_q)
        WIDX_ID:         rd_mux = ID_VALUE;
        WIDX_CTRL:       rd_mux = ctrl_q;
        WIDX_IRQ_STATUS: rd_mux[N_IRQ-1:0] = irq_status_q;
        WIDX_IRQ_MASK:   rd_mux[N_IRQ-1:0] = irq_mask_q;
        WIDX_STATUS:     rd_mux = status_in;
        WIDX_EVT_COUNT:  rd_mux[15:0] = evt_count_q;
        default:         rd_mux = '0;
      endcase
    end
  end

  // Sticky status: W1C clear applied first so a same-cycle event wins.
  always_comb begin
    clr_full     = wdata_q & be_mask(be_q);
    irq_clr      = wr_irq_status ? clr_full[N_IRQ-1:0] : '0;
    irq_status_d = (irq_status_q & ~irq_clr) | irq_src;
  end

  // Handshake FSM with latched request and registered acknowledge/read_data.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q   <= StIdle;
      ack_q     <= 1'b0;
      read_data <= '0;
      widx_q    <= '0;
      rw_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          ack_q <= 1'b0;
          if (bus_enable) begin
            widx_q  <= address[6:2];
            rw_q    <= rw;
            be_q    <= byte_enable;
            wdata_q <= write_data;
            state_q <= StAccess;
          end
        end
        StAccess: begin
          ack_q <= 1'b1;
          if (rw_q) read_data <= rd_mux;
          state_q <= StAck;
        end
        StAck: begin
          ack_q   <= 1'b0;
          state_q <= StRelease;
        end
        StRelease: begin
          ack_q <= 1'b0;
          // Wait for the initiator to drop its strobe so a held request is not re-taken.
          if (!bus_enable) state_q <= StIdle;
        end
        default: begin
          ack_q   <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Reset asserted during the ACK cycle suppresses the pulse in that same cycle.
  assign acknowledge = ack_q & ~reset_reset;

  // Control and interrupt registers plus the saturating event counter.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      ctrl_q       <= '0;
      irq_status_q <= '0;
      irq_mask_q   <= '0;
      evt_count_q  <= '0;
      irq_q        <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl_q <= be_merge(ctrl_q, wdata_q, be_q);
      if (wr_irq_mask) irq_mask_q <= wdata_q[N_IRQ-1:0];
      irq_status_q <= irq_status_d;
      if (wr_evt_count) begin
        evt_count_q <= '0;
      end else if ((|irq_src) && (evt_count_q != 16'hFFFF)) begin
        evt_count_q <= evt_count_q + 16'd1;
      end
      irq_q <= |(irq_status_q & irq_mask_q);
    end
  end

  assign ctrl_out = ctrl_q;
  assign irq      = irq_q;

  currctrl_param_file u_param_file (
    .clk       (clk_clk),
    .reset     (reset_reset),
    .wr_en     (commit_wr && is_param),
    .wr_idx    (param_idx),
    .wr_be     (be_q),
    .wr_data   (wdata_q),
    .bus_idx   (param_idx),
    .bus_rdata (param_bus_rdata),
    .rd_idx    (param_rd_addr),
    .rd_data   (param_rd_data)
  );

endmodule

// File: doc/currctrl_bridge_responder.md
# currctrl_bridge_responder

Responder (slave) end of the current-control external bus bridge. It decodes bridge cycles (bus_enable / rw / address / byte_enable / write_data) into a 32-word register space and answers with a single-cycle acknowledge and read_data. It raises a maskable, sticky interrupt toward the bridge and exposes control, setpoint and parameter registers to the coil-driver logic.

## Interface
- ID_VALUE, 32'h4344_0008, value returned by the ID register.
- N_IRQ, 8, number of interrupt sources, 1..32.
- clk_clk  in  1  single clock; all logic is on its rising edge.
- reset_reset  in  1  synchronous, active-high reset.
- bus_enable  in  1  initiator request strobe; held until acknowledge is seen.
- rw  in  1  1 = read, 0 = write.
- address  in  7  byte address; bits [1:0] are ignored, word index = address[6:2].
- byte_enable  in  4  write byte lanes.
- write_data  in  32  write data.
- acknowledge  out  1  one-cycle completion pulse.
- read_data  out  32  read result, valid while acknowledge = 1.
- irq  out  1  level interrupt, |(irq_status & irq_mask), registered.
- irq_src  in  N_IRQ  per-bit event pulses from the control logic.
- status_in  in  32  live status word, sampled on read.
- ctrl_out  out  32  CTRL register contents.
- param_rd_addr  in  5  internal parameter read index, 0..23.
- param_rd_data  out  32  registered parameter read data.

## Operation
- Register map (byte address):
  - 0x00: ID, read-only.
  - 0x04: CTRL, read/write, byte-enabled.
  - 0x08: IRQ_STATUS, write-1-to-clear, byte-enabled.
  - 0x0C: IRQ_MASK, read/write, N_IRQ bits.
  - 0x10: STATUS, read-only, returns status_in.
  - 0x14: EVT_COUNT, read-only; any write clears it.
  - 0x18–0x1C: reserved; reads return 0, writes are ignored.
  - 0x20–0x7C: PARAM[0..23], read/write, byte-enabled.
- FSM states: IDLE, ACCESS, ACK, RELEASE.
  - IDLE → ACCESS when bus_enable = 1. address, rw, byte_enable and write_data are latched at this transition.
  - ACCESS → ACK unconditionally. The write is committed, or read_data is loaded, at the end of ACCESS.
  - ACK → RELEASE unconditionally. acknowledge = 1 only in ACK.
  - RELEASE → IDLE when bus_enable = 0; otherwise RELEASE holds. This prevents re-triggering on a held strobe.
- IRQ_STATUS bit i sets on any cycle where irq_src[i] = 1. If a set and a W1C clear hit the same bit in the same cycle, the set wins.
- EVT_COUNT increments in any cycle where irq_src ≠ 0. It is 16 bits, zero-extended on read, and saturates at 0xFFFF. If an increment and a clear occur in the same cycle, the clear wins.
- PARAM internal port: param_rd_data = PARAM[param_rd_addr] one cycle later. Indices 24–31 return 0. A same-cycle bus write to the same index returns the old data.
- read_data holds its last value outside ACK.

## Timing
- bus_enable first high in IDLE in cycle c:
  - acknowledge = 1 in cycle c+2.
  - Write data is visible on ctrl_out/param from c+2.
  - Minimum transaction length is 4 cycles when bus_enable drops in c+3.
- irq updates one cycle after the status or mask change.
- Reset values:
  - State = IDLE.
  - acknowledge, read_data, irq, ctrl_out, param_rd_data = 0.
  - IRQ_STATUS, IRQ_MASK, EVT_COUNT and all PARAM = 0.
- Reset during ACCESS or ACK aborts the transaction: no acknowledge, and no write if the reset occurs in the ACCESS cycle. After reset the block starts in IDLE. A still-high bus_enable is then accepted as a new request.
- bus_enable dropping before acknowledge: the transaction still completes and acknowledges. RELEASE then exits immediately.

## Structure
- Package currctrl_bridge_pkg:
  - Register byte-address constants.
  - PARAM_BASE = 0x20 and N_PARAM = 24.
  - The FSM state enum.
  - The byte-enable merge function.
- Sub-module currctrl_param_file: 24×32 array with a byte-enabled write port and a registered internal read port. The FSM and the other registers stay in the top level.

## Test plan
- Write 0xDEADBEEF with byte_enable 4'b0101 to 0x04 after reset → ctrl_out = 0x00AD00EF; acknowledge 2 cycles after bus_enable; read of 0x04 returns 0x00AD00EF.
- Read 0x00 → read_data = 0x43440008 in the acknowledge cycle. Read 0x18 → 0.
- Set IRQ_MASK = 0x05; pulse irq_src = 0x04 → irq = 1 one cycle after the status bit sets. Write 0x04 to 0x08 while irq_src[2] = 1 in the commit cycle → the bit stays set. Repeat with no event → irq = 0.
- Hold bus_enable high for 10 cycles → exactly one acknowledge pulse; the next request is accepted only after bus_enable drops.
- Write PARAM[23] (0x7C) = 0x12345678 and set param_rd_addr = 23 → param_rd_data = 0x12345678 on the next cycle. param_rd_addr = 30 → 0.
- Assert reset_reset in the ACCESS cycle of a write to 0x04 → no acknowledge, ctrl_out = 0, state = IDLE.
